// File: rtl/mem_responder_pkg.sv
// Shared CPU package: default widths for the memory responder and the
// FSM/request encodings the control unit also decodes.
package mem_responder_pkg;

  localparam int unsigned MR_DWIDTH     = 16;
  localparam int unsigned MR_ADDR_WIDTH = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_HOLD   = 3'd4
  } mr_state_e;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2,
    REQ_ERR   = 2'd3
  } mr_req_e;

endpackage

// File: rtl/mem_responder_sp_ram.sv
// Single-port synchronous RAM, read-first, one-cycle read latency.
// The array has no reset so its contents survive a responder reset.
module sp_ram #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DWIDTH-1:0]     wdata,
  output logic [DWIDTH-1:0]     rdata
);

  logic [DWIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one level-held read/write request, inserts
// WAIT_CYCLES wait states, accesses sp_ram and pulses o_done once per request.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DWIDTH      = MR_DWIDTH,
  parameter int unsigned ADDR_WIDTH  = MR_ADDR_WIDTH,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0]     i_wdata,
  output logic [DWIDTH-1:0]     o_rdata,
  output logic                  o_done,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mr_state_e             state_q, state_d;
  mr_req_e               req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0]     wdata_q, wdata_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [DWIDTH-1:0]     rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0]     ram_rdata;
  logic                  ram_we;

  // The RAM sees i_addr while idle so the accept edge already launches the
  // read; this keeps the data ready for ACCESS even with zero wait states.
  assign ram_addr = (state_q == ST_IDLE) ? i_addr : addr_q;
  assign ram_we   = (state_q == ST_ACCESS) && (req_q == REQ_WRITE);

  sp_ram #(
    .DWIDTH     (DWIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_read || i_write) begin
          addr_d  = i_addr;
          wdata_d = i_wdata;
          if (i_read && i_write) begin
            req_d   = REQ_ERR;
            state_d = ST_RESP;
          end else begin
            req_d = i_write ? REQ_WRITE : REQ_READ;
            if (WAIT_CYCLES > 0) begin
              wcnt_d  = WAIT_LOAD;
              state_d = ST_WAIT;
            end else begin
              state_d = ST_ACCESS;
            end
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) state_d = ST_ACCESS;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      ST_ACCESS: begin
        if (req_q == REQ_READ) rdata_d = ram_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_HOLD;
      ST_HOLD: begin
        if (!i_read && !i_write) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Completion flags are registered, so they appear the cycle after RESP.
    done_d = (state_q == ST_RESP);
    err_d  = (state_q == ST_RESP) && (req_q == REQ_ERR);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      req_q   <= REQ_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      wcnt_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign o_rdata = rdata_q;
  assign o_done  = done_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default build (2 wait states) and a
// zero-wait-state build sharing clock and reset.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        i_read = 1'b0, i_write = 1'b0;
  logic [11:0] i_addr = '0;
  logic [15:0] i_wdata = '0;
  logic [15:0] o_rdata;
  logic        o_done, o_busy, o_err;

  logic        i_read0 = 1'b0, i_write0 = 1'b0;
  logic [11:0] i_addr0 = '0;
  logic [15:0] i_wdata0 = '0;
  logic [15:0] o_rdata0;
  logic        o_done0, o_busy0, o_err0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(.DWIDTH(16), .ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .i_read(i_read), .i_write(i_write),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_done(o_done), .o_busy(o_busy), .o_err(o_err)
  );

  mem_responder #(.DWIDTH(16), .ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .i_read(i_read0), .i_write(i_write0),
    .i_addr(i_addr0), .i_wdata(i_wdata0), .o_rdata(o_rdata0),
    .o_done(o_done0), .o_busy(o_busy0), .o_err(o_err0)
  );

  // Inputs must already be driven; the next rising edge is the accept edge.
  // Returns edges from accept to the first o_done, bounded at 40.
  task automatic wait_done(input bit sel, output int cyc, output bit busy_all,
                           output logic [15:0] rd, output logic er);
    cyc = 0;
    busy_all = 1'b1;
    rd = 'x;
    er = 'x;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      cyc++;
      busy_all &= sel ? o_busy0 : o_busy;
      if (sel ? o_done0 : o_done) begin
        rd = sel ? o_rdata0 : o_rdata;
        er = sel ? o_err0 : o_err;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", o_rdata); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", o_err); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_write();
    int cyc; bit ball; logic [15:0] rd; logic er;
    i_write = 1'b1; i_addr = 12'h0A5; i_wdata = 16'hBEEF;
    wait_done(1'b0, cyc, ball, rd, er);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL wr_latency got=%0d exp=4", cyc); end
    checks++; if (ball !== 1'b1) begin errors++; $display("FAIL wr_busy_during got=%b exp=1", ball); end
    checks++; if (rd !== 16'h0) begin errors++; $display("FAIL wr_rdata got=%h exp=0000", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got=%b exp=0", er); end
    @(posedge clk); #1;
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse got=%b exp=0", o_done); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL wr_busy_held got=%b exp=1", o_busy); end
    i_write = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_rearm got=%b exp=0", o_busy); end
  endtask

  task automatic test_read();
    int cyc; bit ball; logic [15:0] rd; logic er;
    i_read = 1'b1; i_addr = 12'h0A5;
    wait_done(1'b0, cyc, ball, rd, er);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL rd_latency got=%0d exp=4", cyc); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data got=%h exp=beef", rd); end
    i_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_data_held got=%h exp=beef", o_rdata); end
  endtask

  task automatic test_held_read();
    int cyc; bit ball; logic [15:0] rd; logic er;
    int pulses;
    i_write = 1'b1; i_addr = 12'hFFF; i_wdata = 16'h1234;
    wait_done(1'b0, cyc, ball, rd, er);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL top_wr_latency got=%0d exp=4", cyc); end
    i_write = 1'b0;
    @(posedge clk); #1;
    pulses = 0;
    i_read = 1'b1; i_addr = 12'hFFF;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin i_addr = 12'h0A5; i_wdata = 16'hDEAD; end
      if (o_done) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
    checks++; if (o_rdata !== 16'h1234) begin errors++; $display("FAIL held_rdata got=%h exp=1234", o_rdata); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL held_busy got=%b exp=1", o_busy); end
    i_read = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL held_rearm got=%b exp=0", o_busy); end
  endtask

  task automatic test_both();
    int cyc; bit ball; logic [15:0] rd; logic er;
    i_read = 1'b1; i_write = 1'b1; i_addr = 12'h0A5; i_wdata = 16'h0000;
    wait_done(1'b0, cyc, ball, rd, er);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL both_latency got=%0d exp=1", cyc); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL both_err got=%b exp=1", er); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL both_rdata got=%h exp=1234", rd); end
    i_read = 1'b0; i_write = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL both_err_pulse got=%b exp=0", o_err); end
    @(posedge clk); #1;
    i_read = 1'b1; i_addr = 12'h0A5;
    wait_done(1'b0, cyc, ball, rd, er);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL both_mem got=%h exp=beef", rd); end
    i_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    int cyc; bit ball; logic [15:0] rd; logic er;
    i_write = 1'b1; i_addr = 12'h010; i_wdata = 16'h0F0F;
    wait_done(1'b0, cyc, ball, rd, er);
    i_write = 1'b0;
    @(posedge clk); #1;
    i_write = 1'b1; i_addr = 12'h010; i_wdata = 16'h5555;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checks++; if (o_rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0000", o_rdata); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    checks++; if ({o_done, o_err} !== 2'b00) begin errors++; $display("FAIL rst_done_err got=%b exp=00", {o_done, o_err}); end
    i_write = 1'b0; i_read = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_done(1'b0, cyc, ball, rd, er);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL rst_new_accept got=%0d exp=4", cyc); end
    checks++; if (rd !== 16'h0F0F) begin errors++; $display("FAIL rst_abort_data got=%h exp=0f0f", rd); end
    i_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait();
    int cyc; bit ball; logic [15:0] rd; logic er;
    i_write0 = 1'b1; i_addr0 = 12'h000; i_wdata0 = 16'h00FF;
    wait_done(1'b1, cyc, ball, rd, er);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL w0_wr_latency got=%0d exp=2", cyc); end
    i_write0 = 1'b0;
    @(posedge clk); #1;
    i_read0 = 1'b1;
    wait_done(1'b1, cyc, ball, rd, er);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL w0_rd_latency got=%0d exp=2", cyc); end
    checks++; if (rd !== 16'h00FF) begin errors++; $display("FAIL w0_rd_data got=%h exp=00ff", rd); end
    i_read0 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_held_read();
    test_both();
    test_reset_mid_wait();
    test_zero_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, word address width; memory depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, extra wait states before each access; legal range 0..15.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_read  in  1  level read request from the control unit.
- i_write  in  1  level write request from the control unit.
- i_addr  in  ADDR_WIDTH  word address.
- i_wdata  in  DWIDTH  write data.
- o_rdata  out  DWIDTH  read data.
- o_done  out  1  one-cycle completion pulse; drives the control unit i_ex_done.
- o_busy  out  1  high from request accept until re-arm.
- o_err  out  1  one-cycle illegal-request pulse.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT, ACCESS, RESP, HOLD.
REQ-006 In IDLE, the block SHALL accept a request at a rising edge where i_read or i_write is high, and SHALL latch i_addr, i_wdata and the request type at that edge.
REQ-007 On accept, the FSM SHALL go to WAIT when WAIT_CYCLES>0, or directly to ACCESS when WAIT_CYCLES=0.
REQ-008 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, then go to ACCESS.
REQ-009 ACCESS SHALL last one cycle: a write commits the latched data at the ACCESS edge; a read captures the RAM output into o_rdata for use in RESP.
REQ-010 RESP SHALL last one cycle with o_done=1.
- Latency: with accept edge E0, o_done is high in the cycle after edge E0+WAIT_CYCLES+2.
REQ-011 o_rdata SHALL update only on a completed read, and SHALL hold its value through writes, errors and idle periods.
REQ-012 HOLD SHALL wait until i_read=0 and i_write=0, then return to IDLE; a held request SHALL never be serviced twice.
REQ-013 A request with i_read=1 and i_write=1 at accept SHALL go directly to RESP with o_done=1 and o_err=1 in the same cycle, with no memory access and o_rdata unchanged.
REQ-014 Changes on i_addr, i_wdata, i_read and i_write after accept and before HOLD exit SHALL be ignored.
REQ-015 o_busy SHALL be 1 in every state except IDLE.
REQ-016 Address arithmetic SHALL be unsigned with no wrap or offset; address 2**ADDR_WIDTH-1 SHALL be accessed normally.

Reset
REQ-017 reset_n=0 SHALL force IDLE immediately, with o_rdata=0, o_done=0, o_busy=0, o_err=0, the wait counter at 0, and the latched request cleared.
REQ-018 Reset during WAIT SHALL abort the request with no write committed.
- A write whose ACCESS edge has already occurred remains in memory.
REQ-019 Memory contents SHALL NOT be cleared by reset.
REQ-020 After reset release, a request held high SHALL be accepted as new.

Structure
REQ-021 DWIDTH and ADDR_WIDTH defaults and the FSM state encodings SHALL be placed in the shared CPU package used by control_unit.
REQ-022 Storage SHALL be a sub-module sp_ram with the following properties:
- single-port, synchronous read and write, one cycle read latency;
- instantiated once;
- no reset on the array.

Verification
REQ-023 Reset release, then write 16'hBEEF to 12'h0A5 with WAIT_CYCLES=2 -> o_done pulses exactly 4 cycles after accept, o_rdata stays 0, o_busy stays high until i_write drops.
REQ-024 Read 12'h0A5 after REQ-023 -> o_done pulse with o_rdata=16'hBEEF, held after i_read drops.
REQ-025 Hold i_read high for 20 cycles at 12'hFFF (preloaded 16'h1234) -> exactly one o_done pulse, o_rdata=16'h1234, no re-accept until i_read is low for at least one cycle.
REQ-026 Assert i_read and i_write together -> o_done and o_err pulse together one cycle after accept, memory unchanged, o_rdata unchanged.
REQ-027 Write 16'h5555 to 12'h010, then assert reset_n=0 mid-WAIT, then read 12'h010 -> old contents returned, all outputs 0 during reset.
REQ-028 WAIT_CYCLES=0 build: write then read back 16'h00FF at 12'h000 -> o_done 2 cycles after each accept, data matches.
